// File: rtl/lsq_mem_ctrl.sv
// LSQ memory-side responder: serializes one 32-bit load/store into byte accesses
// on a byte-wide single-port memory. Optional macro: MEMCTRL_ALIGN_CHECK_EN.
module lsq_mem_ctrl #(
    parameter int ADDR_WIDTH = 20,
    parameter int TAG_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [TAG_WIDTH-1:0]  req_tag,
    output logic                  resp_valid,
    output logic                  resp_wr,
    output logic [TAG_WIDTH-1:0]  resp_tag,
    output logic [31:0]           resp_data,
    output logic                  resp_err,
    output logic                  mem_cs,
    output logic                  mem_re,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [7:0]            mem_wdata,
    input  logic [7:0]            mem_rdata
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DRAIN = 2'd2, RESP = 2'd3} state_t;

    state_t                state_q, state_d;
    logic                  wr_q, wr_d;
    logic [2:0]            f3_q, f3_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [TAG_WIDTH-1:0]  tag_q, tag_d;
    logic [1:0]            idx_q, idx_d, last_q, last_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  ready_q, ready_d;
    logic                  resp_valid_q, resp_valid_d, resp_wr_q, resp_wr_d, resp_err_q, resp_err_d;
    logic [TAG_WIDTH-1:0]  resp_tag_q, resp_tag_d;
    logic [31:0]           resp_data_q, resp_data_d;
    logic                  mem_cs_q, mem_cs_d, mem_re_q, mem_re_d, mem_wr_q, mem_wr_d;
    logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
    logic [7:0]            mem_wdata_q, mem_wdata_d;
    logic [1:0]            nidx_s;
    logic [31:0]           raw_s;
    logic                  align_err_s;
    logic                  unused_addr_s;

    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] lane);
        case (lane)
            2'd0:    byte_sel = w[7:0];
            2'd1:    byte_sel = w[15:8];
            2'd2:    byte_sel = w[23:16];
            default: byte_sel = w[31:24];
        endcase
    endfunction

    function automatic logic [31:0] byte_ins(input logic [31:0] r, input logic [1:0] lane,
                                             input logic [7:0] b);
        case (lane)
            2'd0:    byte_ins = {r[31:8], b};
            2'd1:    byte_ins = {r[31:16], b, r[7:0]};
            2'd2:    byte_ins = {r[31:24], b, r[15:0]};
            default: byte_ins = {b, r[23:0]};
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] r, input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   load_ext = f3[2] ? {24'd0, r[7:0]} : {{24{r[7]}}, r[7:0]};
            2'b01:   load_ext = f3[2] ? {16'd0, r[15:0]} : {{16{r[15]}}, r[15:0]};
            default: load_ext = r;
        endcase
    endfunction

    function automatic logic [1:0] last_idx(input logic [1:0] size);
        case (size)
            2'b00:   last_idx = 2'd0;
            2'b01:   last_idx = 2'd1;
            default: last_idx = 2'd3;
        endcase
    endfunction

`ifdef MEMCTRL_ALIGN_CHECK_EN
    assign align_err_s = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                         (req_funct3[1] && (req_addr[1:0] != 2'b00));
`else
    assign align_err_s = 1'b0;
`endif

    assign unused_addr_s = ^req_addr[31:ADDR_WIDTH];
    assign nidx_s        = idx_q + 2'd1;

    // Next-state, byte sequencing and response formation.
    always_comb begin
        state_d       = state_q;
        wr_d          = wr_q;
        f3_d          = f3_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        tag_d         = tag_q;
        idx_d         = idx_q;
        last_d        = last_q;
        rdata_d       = rdata_q;
        ready_d       = ready_q;
        resp_valid_d  = 1'b0;
        resp_wr_d     = resp_wr_q;
        resp_tag_d    = resp_tag_q;
        resp_data_d   = resp_data_q;
        resp_err_d    = resp_err_q;
        mem_cs_d      = 1'b0;
        mem_re_d      = 1'b0;
        mem_wr_d      = 1'b0;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
        raw_s         = rdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid && ready_q) begin
                    wr_d    = req_wr;
                    f3_d    = req_funct3;
                    addr_d  = req_addr[ADDR_WIDTH-1:0];
                    wdata_d = req_wdata;
                    tag_d   = req_tag;
                    idx_d   = 2'd0;
                    last_d  = last_idx(req_funct3[1:0]);
                    rdata_d = 32'd0;
                    ready_d = 1'b0;
                    if (align_err_s) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_wr_d    = req_wr;
                        resp_tag_d   = req_tag;
                        resp_data_d  = 32'd0;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d       = ACCESS;
                        mem_cs_d      = 1'b1;
                        mem_re_d      = ~req_wr;
                        mem_wr_d      = req_wr;
                        mem_address_d = req_addr[ADDR_WIDTH-1:0];
                        mem_wdata_d   = req_wdata[7:0];
                    end
                end else begin
                    ready_d = 1'b1;
                end
            end
            ACCESS: begin
                // Read data trails the strobe by a cycle, so this cycle holds byte idx-1.
                if (!wr_q && (idx_q != 2'd0)) begin
                    rdata_d = byte_ins(rdata_q, idx_q - 2'd1, mem_rdata);
                end else begin
                    rdata_d = rdata_q;
                end
                if (idx_q == last_q) begin
                    if (wr_q) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_wr_d    = 1'b1;
                        resp_tag_d   = tag_q;
                        resp_data_d  = 32'd0;
                        resp_err_d   = 1'b0;
                    end else begin
                        state_d = DRAIN;
                    end
                end else begin
                    idx_d         = nidx_s;
                    mem_cs_d      = 1'b1;
                    mem_re_d      = ~wr_q;
                    mem_wr_d      = wr_q;
                    mem_address_d = addr_q + {{(ADDR_WIDTH-2){1'b0}}, nidx_s};
                    mem_wdata_d   = byte_sel(wdata_q, nidx_s);
                end
            end
            DRAIN: begin
                raw_s        = byte_ins(rdata_q, last_q, mem_rdata);
                rdata_d      = raw_s;
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_wr_d    = 1'b0;
                resp_tag_d   = tag_q;
                resp_data_d  = load_ext(raw_s, f3_q);
                resp_err_d   = 1'b0;
            end
            RESP: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers; reset drops memory strobes immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            wr_q          <= 1'b0;
            f3_q          <= 3'd0;
            addr_q        <= '0;
            wdata_q       <= 32'd0;
            tag_q         <= '0;
            idx_q         <= 2'd0;
            last_q        <= 2'd0;
            rdata_q       <= 32'd0;
            ready_q       <= 1'b1;
            resp_valid_q  <= 1'b0;
            resp_wr_q     <= 1'b0;
            resp_tag_q    <= '0;
            resp_data_q   <= 32'd0;
            resp_err_q    <= 1'b0;
            mem_cs_q      <= 1'b0;
            mem_re_q      <= 1'b0;
            mem_wr_q      <= 1'b0;
            mem_address_q <= '0;
            mem_wdata_q   <= 8'd0;
        end else begin
            state_q       <= state_d;
            wr_q          <= wr_d;
            f3_q          <= f3_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            tag_q         <= tag_d;
            idx_q         <= idx_d;
            last_q        <= last_d;
            rdata_q       <= rdata_d;
            ready_q       <= ready_d;
            resp_valid_q  <= resp_valid_d;
            resp_wr_q     <= resp_wr_d;
            resp_tag_q    <= resp_tag_d;
            resp_data_q   <= resp_data_d;
            resp_err_q    <= resp_err_d;
            mem_cs_q      <= mem_cs_d;
            mem_re_q      <= mem_re_d;
            mem_wr_q      <= mem_wr_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
        end
    end

    assign req_ready   = ready_q & ~rst;
    assign resp_valid  = resp_valid_q;
    assign resp_wr     = resp_wr_q;
    assign resp_tag    = resp_tag_q;
    assign resp_data   = resp_data_q;
    assign resp_err    = resp_err_q;
    assign mem_cs      = mem_cs_q;
    assign mem_re      = mem_re_q;
    assign mem_wr      = mem_wr_q;
    assign mem_address = mem_address_q;
    assign mem_wdata   = mem_wdata_q;
endmodule

// File: tb/tb_lsq_mem_ctrl.sv
// Scoreboard bench for lsq_mem_ctrl: byte-array reference memory, randomized
// loads/stores, latency/tag/data/error checks, and a mid-store reset.
module tb_lsq_mem_ctrl;
    localparam int AW = 20;
    localparam int TW = 6;
    localparam int AMASK = (1 << AW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_wr;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr, req_wdata;
    logic [TW-1:0] req_tag;
    logic          resp_valid, resp_wr, resp_err;
    logic [TW-1:0] resp_tag;
    logic [31:0]   resp_data;
    logic          mem_cs, mem_re, mem_wr;
    logic [AW-1:0] mem_address;
    logic [7:0]    mem_wdata, mem_rdata;

    lsq_mem_ctrl #(.ADDR_WIDTH(AW), .TAG_WIDTH(TW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_tag(req_tag),
        .resp_valid(resp_valid), .resp_wr(resp_wr), .resp_tag(resp_tag),
        .resp_data(resp_data), .resp_err(resp_err),
        .mem_cs(mem_cs), .mem_re(mem_re), .mem_wr(mem_wr),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Byte-wide memory device attached to the DUT.
    logic [7:0] dev_mem [0:AMASK];
    always @(posedge clk) begin
        if (mem_cs && mem_wr) dev_mem[mem_address] <= mem_wdata;
        if (mem_cs && mem_re) mem_rdata <= dev_mem[mem_address];
    end

    typedef struct {
        logic          wr;
        logic [TW-1:0] tag;
        logic [31:0]   data;
        logic          err;
        int            c0;
        int            lat;
    } exp_t;
    exp_t exp_q[$];

    int ref_mem [int];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : 0;
    endfunction

    // Behavioural model: computes the whole response at issue time.
    task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [TW-1:0] tag, input bit expect_resp);
        int   waitc = 0;
        int   n, a, lat;
        bit   mis;
        longint v;
        exp_t e;
        @(negedge clk);
        while (!req_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        if (!req_ready) begin
            check("ready_timeout", 32'd0, 32'd1);
            return;
        end
        req_valid = 1'b1; req_wr = wr; req_funct3 = f3; req_addr = addr;
        req_wdata = wdata; req_tag = tag;
        n = (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
        a = int'(addr) & AMASK;
        mis = 1'b0;
`ifdef MEMCTRL_ALIGN_CHECK_EN
        mis = (n == 2 && (a % 2) != 0) || (n == 4 && (a % 4) != 0);
`endif
        v = 0;
        if (mis) begin
            lat = 1;
        end else if (wr) begin
            lat = n + 1;
            if (expect_resp)
                for (int i = 0; i < n; i++) ref_mem[(a + i) & AMASK] = int'((wdata >> (8 * i)) & 32'hFF);
        end else begin
            lat = n + 2;
            for (int i = 0; i < n; i++) v = v + (longint'(ref_rd((a + i) & AMASK)) << (8 * i));
            if (!f3[2] && n == 1 && v >= 128) v = v - 256;
            if (!f3[2] && n == 2 && v >= 32768) v = v - 65536;
        end
        e.wr = wr; e.tag = tag; e.data = 32'(v); e.err = mis; e.c0 = cyc; e.lat = lat;
        if (expect_resp) exp_q.push_back(e);
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_wr     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        req_tag    = TW'($urandom);
    endtask

    // Monitor: pops the scoreboard on every response pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            check("strobe_excl", {31'd0, mem_re & mem_wr}, 32'd0);
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_tag", {26'd0, resp_tag}, {26'd0, e.tag});
                    check("resp_wr", {31'd0, resp_wr}, {31'd0, e.wr});
                    check("resp_data", resp_data, e.data);
                    check("resp_err", {31'd0, resp_err}, {31'd0, e.err});
                    check("resp_latency", 32'(cyc - e.c0), 32'(e.lat));
                    check("cs_at_resp", {31'd0, mem_cs}, 32'd0);
                end
            end
        end
    end

    initial begin
        int waitc;
        for (int i = 0; i <= AMASK; i++) dev_mem[i] = 8'h00;
        rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; req_tag = '0;
        repeat (3) @(posedge clk);
        #1;
        check("ready_in_reset", {31'd0, req_ready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_tag", {26'd0, resp_tag}, 32'd0);
        check("rst_data", resp_data, 32'd0);
        check("rst_strobes", {29'd0, mem_cs, mem_re, mem_wr}, 32'd0);
        check("rst_addr", {12'd0, mem_address}, 32'd0);

        // Directed cases.
        issue(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 6'h01, 1'b1);
        issue(1'b0, 3'b010, 32'h0000_0100, 32'h0, 6'h2A, 1'b1);
        issue(1'b0, 3'b000, 32'h0000_0103, 32'h0, 6'h03, 1'b1);
        issue(1'b0, 3'b100, 32'h0000_0103, 32'h0, 6'h04, 1'b1);
        issue(1'b0, 3'b101, 32'h0000_0102, 32'h0, 6'h05, 1'b1);
        issue(1'b0, 3'b001, 32'h0000_0102, 32'h0, 6'h06, 1'b1);
        issue(1'b1, 3'b010, 32'hFFFF_FFFE, 32'h1122_3344, 6'h07, 1'b1);
        issue(1'b0, 3'b010, 32'h000F_FFFE, 32'h0, 6'h08, 1'b1);
        issue(1'b0, 3'b010, 32'h0000_0101, 32'h0, 6'h09, 1'b1);
        issue(1'b0, 3'b011, 32'h0000_0100, 32'h0, 6'h0A, 1'b1);

        // Reset in cycle 2 of a word store: no response, strobes drop at once.
        issue(1'b1, 3'b010, 32'h0004_0000, 32'hCAFE_F00D, 6'h0B, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid_wr", {31'd0, mem_wr}, 32'd0);
        check("rst_mid_cs", {31'd0, mem_cs}, 32'd0);
        check("rst_mid_ready", {31'd0, req_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", {31'd0, req_ready}, 32'd1);
        issue(1'b1, 3'b010, 32'h0004_0000, 32'h1357_9BDF, 6'h0C, 1'b1);
        issue(1'b0, 3'b010, 32'h0004_0000, 32'h0, 6'h0D, 1'b1);

        // Randomized traffic in two windows, one straddling the address wrap.
        for (int k = 0; k < 300; k++) begin
            logic [31:0] base;
            base = ($urandom_range(0, 1) == 0) ? 32'h0000_0100 : 32'hFFFF_FFF0;
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            issue(1'($urandom), 3'($urandom), base + 32'($urandom_range(0, 31)),
                  $urandom, TW'($urandom), 1'b1);
        end

        waitc = 0;
        while (exp_q.size() != 0 && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
